// File: rtl/shk_pkg.sv
// Shared types and width helpers for the shk handshake arbiter.
// Width helpers are functions so each module can size itself from its own parameters.
package shk_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LOCK = 1'b1
  } state_e;

  // Channel-index width (CH_W); never below one bit.
  function automatic int ch_w(input int p_ch);
    return (p_ch > 1) ? $clog2(p_ch) : 1;
  endfunction

  // Outstanding-count width (CNT_W); must hold the value p_outs itself.
  function automatic int cnt_w(input int p_outs);
    return $clog2(p_outs + 1);
  endfunction

endpackage

// File: rtl/shk_id_fifo.sv
// Outstanding-request ID FIFO: records which channel issued each downstream beat.
// Pointers carry an extra wrap bit so full and empty are distinguishable without a counter.
module shk_id_fifo
  import shk_pkg::*;
#(
  parameter int P_DEPTH = 8,
  parameter int P_W     = 2
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_push,
  input  logic                        i_pop,
  input  logic [P_W-1:0]              i_din,
  output logic [P_W-1:0]              o_dout,
  output logic                        o_full,
  output logic                        o_empty,
  output logic [cnt_w(P_DEPTH)-1:0]   o_count
);

  localparam int PTR_W = $clog2(P_DEPTH);

  logic [P_W-1:0] r_mem [P_DEPTH];
  logic [PTR_W:0] r_wr_ptr;
  logic [PTR_W:0] r_rd_ptr;
  logic [PTR_W:0] w_count;
  logic           w_do_push;
  logic           w_do_pop;

  assign w_count   = r_wr_ptr - r_rd_ptr;
  assign o_count   = w_count;
  assign o_full    = (w_count == (PTR_W+1)'(P_DEPTH));
  assign o_empty   = (w_count == '0);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_dout    = r_mem[r_rd_ptr[PTR_W-1:0]];

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; entries are only read once the pointers mark them valid.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_din;
  end

endmodule

// File: rtl/shk_arbiter.sv
// Frame-locked round-robin arbiter merging P_CH shk masters onto one shk slave,
// routing in-order responses back to the issuing channel via an ID FIFO.
module shk_arbiter
  import shk_pkg::*;
#(
  parameter int P_CH   = 4,
  parameter int P_DW   = 32,
  parameter int P_AW   = 32,
  parameter int P_OUTS = 8
) (
  input  logic                       i_sys_clk,
  input  logic                       i_sys_resetn,
  input  logic [P_CH-1:0]            i_up_shk_valid,
  input  logic [P_CH-1:0]            i_up_shk_msync,
  input  logic [P_CH*P_DW-1:0]       i_up_shk_mdata,
  input  logic [P_CH*P_AW-1:0]       i_up_shk_maddr,
  output logic [P_CH-1:0]            o_up_shk_ready,
  output logic [P_CH-1:0]            o_up_shk_ssync,
  output logic [P_DW-1:0]            o_up_shk_sdata,
  output logic [P_AW-1:0]            o_up_shk_saddr,
  output logic                       o_dn_shk_valid,
  output logic                       o_dn_shk_msync,
  output logic [P_DW-1:0]            o_dn_shk_mdata,
  output logic [P_AW-1:0]            o_dn_shk_maddr,
  input  logic                       i_dn_shk_ready,
  input  logic                       i_dn_shk_ssync,
  input  logic [P_DW-1:0]            i_dn_shk_sdata,
  input  logic [P_AW-1:0]            i_dn_shk_saddr,
  output logic [cnt_w(P_OUTS)-1:0]   o_outstanding,
  output logic                       o_err_orphan
);

  localparam int CH_W  = ch_w(P_CH);
  localparam int CNT_W = cnt_w(P_OUTS);

  state_e            r_state;
  state_e            w_next_state;
  logic [CH_W-1:0]   r_grant;
  logic [CH_W-1:0]   r_rr_ptr;
  logic [CH_W-1:0]   w_pick;
  logic [CH_W-1:0]   w_rr_next;
  logic              w_any;
  logic              w_sel_valid;
  logic              w_sel_msync;
  logic [P_DW-1:0]   w_sel_mdata;
  logic [P_AW-1:0]   w_sel_maddr;
  logic              w_hs;
  logic              w_pop;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [CH_W-1:0]   w_fifo_dout;
  logic [CNT_W-1:0]  w_count;
  logic [P_CH-1:0]   r_ssync;
  logic [P_DW-1:0]   r_sdata;
  logic [P_AW-1:0]   r_saddr;
  logic              r_orphan;

  // Round-robin pick: scan offsets high to low so the nearest requester at/after rr_ptr wins.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    for (int i = P_CH-1; i >= 0; i--) begin
      if (i_up_shk_valid[(int'(r_rr_ptr) + i) % P_CH]) begin
        w_any  = 1'b1;
        w_pick = CH_W'((int'(r_rr_ptr) + i) % P_CH);
      end
    end
  end

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_msync = 1'b0;
    w_sel_mdata = '0;
    w_sel_maddr = '0;
    for (int k = 0; k < P_CH; k++) begin
      if (int'(r_grant) == k) begin
        w_sel_valid = i_up_shk_valid[k];
        w_sel_msync = i_up_shk_msync[k];
        w_sel_mdata = i_up_shk_mdata[k*P_DW +: P_DW];
        w_sel_maddr = i_up_shk_maddr[k*P_AW +: P_AW];
      end
    end
  end

  assign o_dn_shk_msync = w_sel_msync;
  assign o_dn_shk_mdata = w_sel_mdata;
  assign o_dn_shk_maddr = w_sel_maddr;
  assign w_hs           = o_dn_shk_valid & i_dn_shk_ready;
  assign w_rr_next      = (r_grant == CH_W'(P_CH-1)) ? '0 : r_grant + 1'b1;

  // NOTE: every signal driven here gets a default first, so no path leaves a latch.
  always_comb begin
    w_next_state   = r_state;
    o_dn_shk_valid = 1'b0;
    o_up_shk_ready = '0;
    case (r_state)
      S_IDLE: begin
        if (w_any) w_next_state = S_LOCK;
      end
      S_LOCK: begin
        o_dn_shk_valid          = w_sel_valid & ~w_fifo_full;
        o_up_shk_ready[r_grant] = i_dn_shk_ready & ~w_fifo_full;
        if (w_hs && w_sel_msync) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
    if (!i_sys_resetn) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_IDLE && w_any) r_grant  <= w_pick;
      if (w_hs && w_sel_msync)        r_rr_ptr <= w_rr_next;
    end
  end

  // Full is judged on the current count, so a same-cycle pop never admits an extra push.
  shk_id_fifo #(
    .P_DEPTH (P_OUTS),
    .P_W     (CH_W)
  ) u_id_fifo (
    .i_clk   (i_sys_clk),
    .i_rst_n (i_sys_resetn),
    .i_push  (w_hs),
    .i_pop   (w_pop),
    .i_din   (r_grant),
    .o_dout  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_count)
  );

  assign w_pop         = i_dn_shk_ssync & ~w_fifo_empty;
  assign o_outstanding = w_count;

  always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
    if (!i_sys_resetn) begin
      r_ssync  <= '0;
      r_sdata  <= '0;
      r_saddr  <= '0;
      r_orphan <= 1'b0;
    end else begin
      r_ssync <= w_pop ? (P_CH'(1) << w_fifo_dout) : '0;
      if (w_pop) begin
        r_sdata <= i_dn_shk_sdata;
        r_saddr <= i_dn_shk_saddr;
      end
      if (i_dn_shk_ssync && w_fifo_empty) r_orphan <= 1'b1;
    end
  end

  assign o_up_shk_ssync = r_ssync;
  assign o_up_shk_sdata = r_sdata;
  assign o_up_shk_saddr = r_saddr;
  assign o_err_orphan   = r_orphan;

endmodule

// File: tb/tb_shk_arbiter.sv
// Self-checking bench for shk_arbiter: directed scenarios with literal expectations
// plus a randomized phase, all cross-checked every cycle by a queue-based model.
module tb_shk_arbiter;

  localparam int P_CH   = 4;
  localparam int P_DW   = 32;
  localparam int P_AW   = 32;
  localparam int P_OUTS = 8;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [P_CH-1:0]     up_valid = '0;
  logic [P_CH-1:0]     up_msync = '0;
  logic [P_CH*P_DW-1:0] up_mdata = '0;
  logic [P_CH*P_AW-1:0] up_maddr = '0;
  logic [P_CH-1:0]     up_ready;
  logic [P_CH-1:0]     up_ssync;
  logic [P_DW-1:0]     up_sdata;
  logic [P_AW-1:0]     up_saddr;
  logic                dn_valid;
  logic                dn_msync;
  logic [P_DW-1:0]     dn_mdata;
  logic [P_AW-1:0]     dn_maddr;
  logic                dn_ready = 1'b0;
  logic                dn_ssync = 1'b0;
  logic [P_DW-1:0]     dn_sdata = '0;
  logic [P_AW-1:0]     dn_saddr = '0;
  logic [3:0]          outstanding;
  logic                err_orphan;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  shk_arbiter #(
    .P_CH(P_CH), .P_DW(P_DW), .P_AW(P_AW), .P_OUTS(P_OUTS)
  ) dut (
    .i_sys_clk      (clk),
    .i_sys_resetn   (rst_n),
    .i_up_shk_valid (up_valid),
    .i_up_shk_msync (up_msync),
    .i_up_shk_mdata (up_mdata),
    .i_up_shk_maddr (up_maddr),
    .o_up_shk_ready (up_ready),
    .o_up_shk_ssync (up_ssync),
    .o_up_shk_sdata (up_sdata),
    .o_up_shk_saddr (up_saddr),
    .o_dn_shk_valid (dn_valid),
    .o_dn_shk_msync (dn_msync),
    .o_dn_shk_mdata (dn_mdata),
    .o_dn_shk_maddr (dn_maddr),
    .i_dn_shk_ready (dn_ready),
    .i_dn_shk_ssync (dn_ssync),
    .i_dn_shk_sdata (dn_sdata),
    .i_dn_shk_saddr (dn_saddr),
    .o_outstanding  (outstanding),
    .o_err_orphan   (err_orphan)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek();
    #1;
  endtask

  task automatic set_ch(input int k, input logic v, input logic s,
                        input logic [P_AW-1:0] a, input logic [P_DW-1:0] d);
    up_valid[k] = v;
    up_msync[k] = s;
    up_maddr[k*P_AW +: P_AW] = a;
    up_mdata[k*P_DW +: P_DW] = d;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      dn_ssync = 1'b1;
      dn_sdata = $urandom();
      dn_saddr = $urandom();
      tick();
    end
    dn_ssync = 1'b0;
    peek();
    check("drain_outstanding", outstanding, 0);
  endtask

  task automatic one_beat(input int k, input logic [P_AW-1:0] a);
    set_ch(k, 1'b1, 1'b1, a, a + 32'h1000);
    tick();
    tick();
    set_ch(k, 1'b0, 1'b0, '0, '0);
  endtask

  // ---------------- behavioural reference model ----------------
  bit              m_locked;
  int              m_grant;
  int              m_rr;
  int              m_q[$];
  logic [P_CH-1:0] m_ssync;
  logic [P_DW-1:0] m_sdata;
  logic [P_AW-1:0] m_saddr;
  bit              m_orphan;
  bit              m_full;
  bit              m_found;
  logic [P_CH-1:0] e_ready;
  logic            e_dnv;

  initial begin
    m_locked = 0; m_grant = 0; m_rr = 0; m_ssync = '0;
    m_sdata = '0; m_saddr = '0; m_orphan = 0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      m_locked = 0; m_grant = 0; m_rr = 0; m_q.delete();
      m_ssync = '0; m_sdata = '0; m_saddr = '0; m_orphan = 0;
    end
    m_full  = (m_q.size() >= P_OUTS);
    e_ready = '0;
    e_dnv   = 1'b0;
    if (m_locked) begin
      e_dnv = up_valid[m_grant] && !m_full;
      if (dn_ready && !m_full) e_ready[m_grant] = 1'b1;
    end
    check("m_ready", up_ready, e_ready);
    check("m_dn_valid", dn_valid, e_dnv);
    if (e_dnv) begin
      check("m_dn_msync", dn_msync, up_msync[m_grant]);
      check("m_dn_maddr", dn_maddr, up_maddr[m_grant*P_AW +: P_AW]);
      check("m_dn_mdata", dn_mdata, up_mdata[m_grant*P_DW +: P_DW]);
    end
    check("m_ssync", up_ssync, m_ssync);
    check("m_sdata", up_sdata, m_sdata);
    check("m_saddr", up_saddr, m_saddr);
    check("m_outstanding", outstanding, m_q.size());
    check("m_orphan", err_orphan, m_orphan);
    if (rst_n) begin
      m_ssync = '0;
      if (dn_ssync) begin
        if (m_q.size() > 0) begin
          m_ssync[m_q.pop_front()] = 1'b1;
          m_sdata = dn_sdata;
          m_saddr = dn_saddr;
        end else begin
          m_orphan = 1;
        end
      end
      if (e_dnv && dn_ready) begin
        m_q.push_back(m_grant);
        if (up_msync[m_grant]) begin
          m_locked = 0;
          m_rr = (m_grant + 1) % P_CH;
        end
      end else if (!m_locked && (|up_valid)) begin
        m_found = 0;
        for (int off = 0; off < P_CH; off++) begin
          if (!m_found && up_valid[(m_rr + off) % P_CH]) begin
            m_grant = (m_rr + off) % P_CH;
            m_found = 1;
          end
        end
        m_locked = 1;
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    repeat (3) tick();
    check("rst_ready", up_ready, 0);
    check("rst_dn_valid", dn_valid, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_orphan", err_orphan, 0);
    rst_n = 1'b1;
    dn_ready = 1'b1;

    // Single channel 3-beat frame on ch2
    set_ch(2, 1'b1, 1'b0, 32'h10, 32'hD0);
    peek();
    check("sc_arb_ready", up_ready, 4'b0000);
    check("sc_arb_dnv", dn_valid, 0);
    tick();
    peek();
    check("sc_b1_ready", up_ready, 4'b0100);
    check("sc_b1_addr", dn_maddr, 32'h10);
    tick();
    set_ch(2, 1'b1, 1'b0, 32'h11, 32'hD1);
    peek();
    check("sc_b2_addr", dn_maddr, 32'h11);
    check("sc_out1", outstanding, 1);
    tick();
    set_ch(2, 1'b1, 1'b1, 32'h12, 32'hD2);
    peek();
    check("sc_b3_msync", dn_msync, 1);
    check("sc_out2", outstanding, 2);
    tick();
    set_ch(2, 1'b0, 1'b0, '0, '0);
    peek();
    check("sc_out3", outstanding, 3);
    check("sc_idle_dnv", dn_valid, 0);
    dn_ssync = 1'b1; dn_sdata = 32'h100;
    tick();
    dn_sdata = 32'h101;
    peek();
    check("sc_r1_ssync", up_ssync, 4'b0100);
    check("sc_r1_sdata", up_sdata, 32'h100);
    check("sc_r1_out", outstanding, 2);
    tick();
    dn_sdata = 32'h102;
    peek();
    check("sc_r2_ssync", up_ssync, 4'b0100);
    check("sc_r2_out", outstanding, 1);
    tick();
    dn_ssync = 1'b0;
    peek();
    check("sc_r3_ssync", up_ssync, 4'b0100);
    check("sc_r3_sdata", up_sdata, 32'h102);
    check("sc_r3_out", outstanding, 0);
    tick();
    peek();
    check("sc_ssync_clear", up_ssync, 0);

    // Round-robin with all channels requesting 1-beat frames, from a fresh reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < P_CH; k++) set_ch(k, 1'b1, 1'b1, 32'h40 + k, 32'h50 + k);
    for (int c = 0; c < 10; c++) begin
      logic [P_CH-1:0] exp_r;
      exp_r = '0;
      if (c % 2 == 1) exp_r[((c - 1) / 2) % P_CH] = 1'b1;
      peek();
      check($sformatf("rr_c%0d", c), up_ready, exp_r);
      tick();
    end
    for (int k = 0; k < P_CH; k++) set_ch(k, 1'b0, 1'b0, '0, '0);
    peek();
    check("rr_out", outstanding, 5);
    drain(5);

    // Frame lock: ch1 4-beat frame, ch0 arrives mid-frame, ch1 valid gaps for 2 cycles
    set_ch(1, 1'b1, 1'b0, 32'h20, 32'h0);
    peek();
    check("fl_arb", up_ready, 4'b0000);
    tick();
    peek();
    check("fl_b1", up_ready, 4'b0010);
    tick();
    set_ch(0, 1'b1, 1'b1, 32'h30, 32'h0);
    peek();
    check("fl_b2", up_ready, 4'b0010);
    tick();
    up_valid[1] = 1'b0;
    peek();
    check("fl_gap1_ready", up_ready, 4'b0010);
    check("fl_gap1_dnv", dn_valid, 0);
    tick();
    peek();
    check("fl_gap2_ready", up_ready, 4'b0010);
    tick();
    up_valid[1] = 1'b1;
    peek();
    check("fl_b3_dnv", dn_valid, 1);
    check("fl_b3_ready", up_ready, 4'b0010);
    tick();
    up_msync[1] = 1'b1;
    peek();
    check("fl_b4_ready", up_ready, 4'b0010);
    tick();
    set_ch(1, 1'b0, 1'b0, '0, '0);
    peek();
    check("fl_bubble", up_ready, 4'b0000);
    tick();
    peek();
    check("fl_ch0_grant", up_ready, 4'b0001);
    check("fl_ch0_addr", dn_maddr, 32'h30);
    tick();
    set_ch(0, 1'b0, 1'b0, '0, '0);
    peek();
    check("fl_out", outstanding, 5);
    drain(5);

    // FIFO full on a long ch3 frame
    set_ch(3, 1'b1, 1'b0, 32'h60, 32'h0);
    tick();
    for (int i = 0; i < P_OUTS; i++) begin
      peek();
      check($sformatf("ff_beat%0d", i), up_ready, 4'b1000);
      tick();
    end
    peek();
    check("ff_full_out", outstanding, 8);
    check("ff_full_ready", up_ready, 4'b0000);
    check("ff_full_dnv", dn_valid, 0);
    dn_ssync = 1'b1; dn_sdata = 32'h77;
    tick();
    dn_ssync = 1'b0;
    up_msync[3] = 1'b1;
    peek();
    check("ff_unstall_ready", up_ready, 4'b1000);
    check("ff_unstall_out", outstanding, 7);
    check("ff_unstall_ssync", up_ssync, 4'b1000);
    tick();
    set_ch(3, 1'b0, 1'b0, '0, '0);
    peek();
    check("ff_ninth_out", outstanding, 8);
    drain(8);

    // Interleaved routing ch0, ch3, ch1 with a push/pop collision
    one_beat(0, 32'h70);
    one_beat(3, 32'h73);
    set_ch(1, 1'b1, 1'b1, 32'h71, 32'h0);
    peek();
    check("il_out2", outstanding, 2);
    tick();
    dn_ssync = 1'b1; dn_sdata = 32'hA;
    peek();
    check("il_ch1_ready", up_ready, 4'b0010);
    tick();
    set_ch(1, 1'b0, 1'b0, '0, '0);
    dn_sdata = 32'hB;
    peek();
    check("il_collide_out", outstanding, 2);
    check("il_r0_ssync", up_ssync, 4'b0001);
    check("il_r0_sdata", up_sdata, 32'hA);
    tick();
    dn_sdata = 32'hC;
    peek();
    check("il_r3_ssync", up_ssync, 4'b1000);
    check("il_r3_sdata", up_sdata, 32'hB);
    check("il_r3_out", outstanding, 1);
    tick();
    dn_ssync = 1'b0;
    peek();
    check("il_r1_ssync", up_ssync, 4'b0010);
    check("il_r1_sdata", up_sdata, 32'hC);
    check("il_r1_out", outstanding, 0);

    // Orphan response, then reset mid-frame and recovery
    peek();
    check("or_before", err_orphan, 0);
    dn_ssync = 1'b1; dn_sdata = 32'hDEAD;
    tick();
    dn_ssync = 1'b0;
    peek();
    check("or_set", err_orphan, 1);
    check("or_no_ssync", up_ssync, 0);
    check("or_out", outstanding, 0);
    set_ch(2, 1'b1, 1'b0, 32'h90, 32'h0);
    tick();
    tick();
    peek();
    check("rm_out1", outstanding, 1);
    rst_n = 1'b0;
    set_ch(2, 1'b0, 1'b0, '0, '0);
    peek();
    check("rm_ready", up_ready, 0);
    check("rm_dnv", dn_valid, 0);
    check("rm_ssync", up_ssync, 0);
    check("rm_sdata", up_sdata, 0);
    check("rm_out", outstanding, 0);
    check("rm_orphan", err_orphan, 0);
    tick();
    rst_n = 1'b1;
    dn_ssync = 1'b1;
    tick();
    dn_ssync = 1'b0;
    peek();
    check("rm_late_orphan", err_orphan, 1);
    set_ch(1, 1'b1, 1'b1, 32'h55, 32'h66);
    peek();
    check("rc_arb", up_ready, 0);
    tick();
    peek();
    check("rc_ready", up_ready, 4'b0010);
    check("rc_addr", dn_maddr, 32'h55);
    tick();
    set_ch(1, 1'b0, 1'b0, '0, '0);
    peek();
    check("rc_out", outstanding, 1);
    dn_ssync = 1'b1; dn_sdata = 32'h77;
    tick();
    dn_ssync = 1'b0;
    peek();
    check("rc_ssync", up_ssync, 4'b0010);
    check("rc_sdata", up_sdata, 32'h77);
    check("rc_out0", outstanding, 0);

    // Randomized traffic; the model process checks every cycle
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int k = 0; k < P_CH; k++)
        set_ch(k, ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 30),
               $urandom(), $urandom());
      dn_ready = ($urandom_range(0, 99) < 80);
      dn_ssync = ($urandom_range(0, 99) < 35);
      dn_sdata = $urandom();
      dn_saddr = $urandom();
      rst_n    = ($urandom_range(0, 499) != 0);
      tick();
    end
    rst_n = 1'b1;
    up_valid = '0;
    up_msync = '0;
    dn_ssync = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shk_arbiter.md
# shk_arbiter

N-channel arbiter for the shk handshake bus: merges P_CH upstream shk masters onto one downstream shk slave. Grant is frame-locked and round-robin. Each request beat expects exactly one in-order response, and responses are routed back to the issuing channel through an outstanding-request ID FIFO. It sits between the frame-generating agents and the single shared register/data slave.

## Interface
Parameters:
- P_CH, 4: upstream channel count, 2..16
- P_DW, 32: mdata/sdata width
- P_AW, 32: maddr/saddr width
- P_OUTS, 8: maximum outstanding requests; power of two, ≥2

Ports:
- i_sys_clk  in  1  system clock
- i_sys_resetn  in  1  asynchronous active-low reset
- i_up_shk_valid  in  P_CH  per-channel request valid
- i_up_shk_msync  in  P_CH  per-channel end-of-frame marker, qualified by valid
- i_up_shk_mdata  in  P_CH*P_DW  packed request data; channel k at [k*P_DW +: P_DW]
- i_up_shk_maddr  in  P_CH*P_AW  packed request address
- o_up_shk_ready  out  P_CH  per-channel request ready
- o_up_shk_ssync  out  P_CH  per-channel response strobe, one cycle
- o_up_shk_sdata  out  P_DW  response data, shared; valid where ssync is high
- o_up_shk_saddr  out  P_AW  response address, shared
- o_dn_shk_valid / o_dn_shk_msync  out  1  downstream request valid / end-of-frame
- o_dn_shk_mdata / o_dn_shk_maddr  out  P_DW / P_AW  downstream request data/address
- i_dn_shk_ready  in  1  downstream ready
- i_dn_shk_ssync  in  1  downstream response strobe; no backpressure
- i_dn_shk_sdata / i_dn_shk_saddr  in  P_DW / P_AW  downstream response data/address
- o_outstanding  out  $clog2(P_OUTS+1)  current outstanding request count
- o_err_orphan  out  1  sticky: response received with no outstanding request

## Operation
- Beat transfer: valid & ready high in the same cycle. msync=1 on the last beat of a frame.
- FSM S_IDLE / S_LOCK; reset state S_IDLE.
- S_IDLE:
  - All o_up_shk_ready are 0 and o_dn_shk_valid is 0.
  - If any i_up_shk_valid is high, pick the first requesting channel at or after rr_ptr, cyclically. Register it as grant and go to S_LOCK.
  - rr_ptr resets to 0.
- S_LOCK, with g = grant:
  - o_dn_shk_valid = i_up_shk_valid[g] & ~fifo_full.
  - o_dn_shk_msync/mdata/maddr = channel g fields. These are combinational passthrough.
  - o_up_shk_ready[g] = i_dn_shk_ready & ~fifo_full. Every other channel's ready is 0.
- Every downstream handshake pushes g into the ID FIFO.
- A handshake with msync=1 moves the FSM to S_IDLE and sets rr_ptr = (g+1) mod P_CH.
- Granted valid dropping mid-frame does not release the grant; the frame stays locked.
- fifo_full is computed from the current count only. A same-cycle pop does not un-stall, so the count never exceeds P_OUTS.
- Response path, when i_dn_shk_ssync is high:
  - FIFO non-empty: pop head h. Next cycle o_up_shk_ssync[h]=1, sdata/saddr are the registered downstream values, and all other ssync bits are 0.
  - FIFO empty: the response is dropped, o_err_orphan is set, and the count is unchanged.
- Simultaneous push and pop: count unchanged, and both operations take effect.
- o_outstanding equals the FIFO count.
- o_err_orphan clears only on reset.

## Timing
- Reset values:
  - FSM S_IDLE, rr_ptr 0, FIFO empty.
  - All o_up_shk_ready, o_up_shk_ssync and o_dn_shk_valid 0.
  - sdata/saddr 0, o_outstanding 0, o_err_orphan 0.
- Reset mid-frame aborts the frame and discards outstanding IDs. Responses arriving after reset count as orphans.
- Arbitration latency: one cycle from the first valid in S_IDLE to S_LOCK. The earliest beat completes in the S_LOCK cycle.
- One-cycle bubble (S_IDLE) between consecutive frames, even for the same channel.
- Request path: zero added latency, combinational in S_LOCK.
- Response path: exactly one cycle of latency, from i_dn_shk_ssync to o_up_shk_ssync.
- Sustained throughput: one beat per cycle while ready is high and the FIFO is not full.

## Structure
- Package shk_pkg:
  - state enum (S_IDLE, S_LOCK)
  - localparams CH_W = $clog2(P_CH) and CNT_W = $clog2(P_OUTS+1), provided as functions of the parameters
- Sub-module shk_id_fifo:
  - synchronous FIFO of CH_W-bit entries, depth P_OUTS
  - ports: push, pop, din, dout, full, empty, count
  - pointers wrap modulo P_OUTS, with an extra MSB to distinguish full from empty
- Top level holds the FSM, round-robin picker and response register.

## Test plan
- Single channel: ch2 sends a 3-beat frame (addr 0x10..0x12, msync on beat 3) with downstream ready held at 1. Beats pass in 3 consecutive cycles after 1 arbitration cycle. Then 3 ssync pulses give o_up_shk_ssync=0b0100 each, and o_outstanding goes 1,2,3→0.
- Round-robin: all 4 channels continuously valid, 1-beat frames. Grant order is 0,1,2,3,0, with one idle cycle between grants.
- Frame lock: ch1 sends a 4-beat frame while ch0 raises valid at beat 2. ch0 is not granted until after ch1's msync beat. ch1 valid dropping for 2 cycles mid-frame keeps the grant.
- FIFO full: P_OUTS=8 with no responses. After 8 beats ready drops and o_outstanding=8. A single ssync restores ready the following cycle, and the 9th beat passes.
- Interleaved routing: ch0, ch3 and ch1 issue one beat each. Three responses with sdata 0xA,0xB,0xC arrive on ch0, ch3, ch1 respectively, with an ssync coinciding with a push that leaves the count unchanged.
- Orphan and reset: ssync with the FIFO empty sets o_err_orphan. Asserting reset mid-frame clears all outputs to their reset values. The bench checks recovery on the next frame.
